// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and types for the FFT stage scheduler
package fft_pkg;

    localparam int N_POINTS = 64;
    localparam int LOG2_N   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fft_sched_state_t;

    typedef logic [LOG2_N-1:0] fft_addr_t;
    typedef logic [LOG2_N-2:0] fft_tw_t;
    typedef logic [LOG2_N-2:0] fft_k_t;
    typedef logic [2:0]        fft_stage_t;

    // One slot of the write-back delay line.
    typedef struct packed {
        logic      en;
        fft_addr_t addr_a;
        fft_addr_t addr_b;
    } fft_wb_t;

endpackage

// File: rtl/fft_stage_scheduler_if.sv
// rtl/fft_stage_scheduler_if.sv - job control and datapath control bundle of the scheduler
interface fft_stage_scheduler_if;
    import fft_pkg::*;

    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       load_en;
    logic       bf_valid;
    fft_addr_t  addr_a;
    fft_addr_t  addr_b;
    fft_tw_t    tw_idx;
    fft_stage_t stage;
    logic       wb_en;
    fft_addr_t  wb_addr_a;
    fft_addr_t  wb_addr_b;

    modport master (
        output start, abort,
        input  busy, done, load_en, bf_valid, addr_a, addr_b, tw_idx, stage,
        input  wb_en, wb_addr_a, wb_addr_b
    );

    modport slave (
        input  start, abort,
        output busy, done, load_en, bf_valid, addr_a, addr_b, tw_idx, stage,
        output wb_en, wb_addr_a, wb_addr_b
    );

endinterface

// File: rtl/fft_bf_addr_gen.sv
// rtl/fft_bf_addr_gen.sv - butterfly operand addresses and twiddle index for (stage, k)
module fft_bf_addr_gen
    import fft_pkg::*;
(
    input  fft_stage_t stage,
    input  fft_k_t     k,
    output fft_addr_t  addr_a,
    output fft_addr_t  addr_b,
    output fft_tw_t    tw_idx
);

    fft_addr_t span;
    fft_addr_t pos;
    fft_addr_t grp;

    // Insert a zero at bit position 'stage' of k to get the upper leg; the lower leg is span above.
    always_comb begin
        span   = fft_addr_t'(1) << stage;
        pos    = fft_addr_t'(k) & (span - fft_addr_t'(1));
        grp    = fft_addr_t'(k) >> stage;
        addr_a = (grp << (stage + 3'd1)) | pos;
        addr_b = addr_a + span;
        tw_idx = fft_tw_t'(pos << (3'(LOG2_N - 1) - stage));
    end

endmodule

// File: rtl/fft_stage_scheduler.sv
// rtl/fft_stage_scheduler.sv - FSM sequencing load, butterfly issue, drain and write-back
module fft_stage_scheduler
    import fft_pkg::*;
#(
    parameter int BF_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_stage_scheduler_if.slave  bus
);

    localparam fft_k_t       K_LAST     = fft_k_t'(N_POINTS / 2 - 1);
    localparam fft_stage_t   STAGE_LAST = fft_stage_t'(LOG2_N - 1);
    localparam logic [2:0]   DRAIN_LAST = 3'(BF_LATENCY - 1);

    fft_sched_state_t state;
    fft_stage_t       stage_q;
    fft_k_t           k_q;
    logic [2:0]       drain_cnt;
    logic             busy_q;
    logic             done_q;
    logic             load_en_q;
    logic             bf_valid_q;
    fft_addr_t        addr_a_q;
    fft_addr_t        addr_b_q;
    fft_tw_t          tw_q;

    fft_stage_t       gen_stage;
    fft_k_t           gen_k;
    fft_addr_t        gen_a;
    fft_addr_t        gen_b;
    fft_tw_t          gen_tw;

    logic             abort_hit;
    logic             flush;
    fft_wb_t          wb_pipe [BF_LATENCY];

    assign abort_hit = bus.abort && (state != ST_IDLE);
    assign flush     = rst || abort_hit;

    // Look-ahead: the generator always sees the butterfly that will be shown next cycle.
    always_comb begin
        gen_stage = '0;
        gen_k     = '0;
        if (state == ST_RUN) begin
            gen_stage = stage_q;
            gen_k     = k_q + fft_k_t'(1);
        end else if (state == ST_DRAIN) begin
            gen_stage = stage_q + 3'd1;
        end
    end

    fft_bf_addr_gen u_addr_gen (
        .stage  (gen_stage),
        .k      (gen_k),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // Job sequencer; k_q is the butterfly currently presented on addr_a/addr_b/tw_idx.
    always_ff @(posedge clk) begin
        if (flush) begin
            state      <= ST_IDLE;
            stage_q    <= '0;
            k_q        <= '0;
            drain_cnt  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_en_q  <= 1'b0;
            bf_valid_q <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            tw_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            load_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_LOAD;
                        busy_q    <= 1'b1;
                        load_en_q <= 1'b1;
                        stage_q   <= '0;
                        k_q       <= '0;
                    end
                end
                ST_LOAD: begin
                    state      <= ST_RUN;
                    bf_valid_q <= 1'b1;
                    addr_a_q   <= gen_a;
                    addr_b_q   <= gen_b;
                    tw_q       <= gen_tw;
                    k_q        <= '0;
                end
                ST_RUN: begin
                    if (k_q == K_LAST) begin
                        state      <= ST_DRAIN;
                        bf_valid_q <= 1'b0;
                        drain_cnt  <= '0;
                    end else begin
                        k_q      <= k_q + fft_k_t'(1);
                        addr_a_q <= gen_a;
                        addr_b_q <= gen_b;
                        tw_q     <= gen_tw;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        if (stage_q == STAGE_LAST) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            stage_q    <= stage_q + 3'd1;
                            k_q        <= '0;
                            bf_valid_q <= 1'b1;
                            addr_a_q   <= gen_a;
                            addr_b_q   <= gen_b;
                            tw_q       <= gen_tw;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write-back delay line matching the butterfly pipeline; emptied on reset or abort.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                wb_pipe[i] <= '0;
            end
        end else begin
            wb_pipe[0] <= {bf_valid_q, addr_a_q, addr_b_q};
            for (int i = 1; i < BF_LATENCY; i++) begin
                wb_pipe[i] <= wb_pipe[i-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.load_en   = load_en_q;
    assign bus.bf_valid  = bf_valid_q;
    assign bus.addr_a    = addr_a_q;
    assign bus.addr_b    = addr_b_q;
    assign bus.tw_idx    = tw_q;
    assign bus.stage     = stage_q;
    assign bus.wb_en     = wb_pipe[BF_LATENCY-1].en;
    assign bus.wb_addr_a = wb_pipe[BF_LATENCY-1].addr_a;
    assign bus.wb_addr_b = wb_pipe[BF_LATENCY-1].addr_b;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// tb/tb_fft_stage_scheduler.sv - scoreboard bench for two scheduler builds (latency 2 and 4)
module tb_fft_stage_scheduler;

    typedef struct {
        int cyc;
        int s;
        int k;
        int a;
        int b;
        int tw;
    } ev_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       load_en;
        logic       bf_valid;
        logic [5:0] addr_a;
        logic [5:0] addr_b;
        logic [4:0] tw;
        logic [2:0] stage;
        logic       wb_en;
        logic [5:0] wb_a;
        logic [5:0] wb_b;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s [2];
    logic abort_s [2];
    obs_t obs [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_on = 0;
    int   lat [2] = '{2, 4};
    int   lo [2] = '{0, 0};
    int   hi [2] = '{-1, -1};
    int   last_done [2] = '{-1, -1};
    int   last_load [2] = '{-1, -1};
    int   last_wb [2] = '{-1, -1};
    logic [63:0] seen_mask [2];
    int   seen_cnt [2];

    // queue index = kind*2 + dut, kinds: 0 load, 1 issue, 2 write-back, 3 done
    ev_t  evq [8][$];

    fft_stage_scheduler_if bus0 ();
    fft_stage_scheduler_if bus1 ();

    assign bus0.start = start_s[0];
    assign bus0.abort = abort_s[0];
    assign bus1.start = start_s[1];
    assign bus1.abort = abort_s[1];
    assign obs[0] = {bus0.busy, bus0.done, bus0.load_en, bus0.bf_valid, bus0.addr_a, bus0.addr_b,
                     bus0.tw_idx, bus0.stage, bus0.wb_en, bus0.wb_addr_a, bus0.wb_addr_b};
    assign obs[1] = {bus1.busy, bus1.done, bus1.load_en, bus1.bf_valid, bus1.addr_a, bus1.addr_b,
                     bus1.tw_idx, bus1.stage, bus1.wb_en, bus1.wb_addr_a, bus1.wb_addr_b};

    fft_stage_scheduler #(.BF_LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    fft_stage_scheduler #(.BF_LATENCY(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int d, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endfunction

    // Drop expected events the DUT never produced, then match a presented event against the head.
    function automatic bit take(int qi, bit seen, string nm, int d, output ev_t e);
        take = 0;
        e = '{cyc: 0, s: 0, k: 0, a: 0, b: 0, tw: 0};
        while (evq[qi].size() > 0 && evq[qi][0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s dut%0d: expected at cycle %0d, not seen (now %0d)", nm, d, evq[qi][0].cyc, cyc);
            void'(evq[qi].pop_front());
        end
        if (seen) begin
            n_checks++;
            if (evq[qi].size() == 0 || evq[qi][0].cyc != cyc) begin
                n_fail++;
                $display("FAIL %s dut%0d: unexpected at cycle %0d", nm, d, cyc);
            end else begin
                e = evq[qi].pop_front();
                take = 1;
            end
        end
    endfunction

    // Reference job timeline built from the stage/butterfly arithmetic.
    function automatic void push_job(int d, int c0);
        int per = 32 + lat[d];
        for (int st = 0; st < 6; st++) begin
            for (int kk = 0; kk < 32; kk++) begin
                int span = 1 << st;
                int pos  = kk % span;
                int a    = (kk / span) * 2 * span + pos;
                int t    = c0 + 2 + st * per + kk;
                evq[2+d].push_back('{cyc: t, s: st, k: kk, a: a, b: a + span, tw: pos << (5 - st)});
                evq[4+d].push_back('{cyc: t + lat[d], s: st, k: kk, a: a, b: a + span, tw: 0});
            end
        end
        evq[d].push_back('{cyc: c0 + 1, s: 0, k: 0, a: 0, b: 0, tw: 0});
        evq[6+d].push_back('{cyc: c0 + 2 + 6 * per, s: 0, k: 0, a: 0, b: 0, tw: 0});
        lo[d] = c0 + 1;
        hi[d] = c0 + 2 + 6 * per;
    endfunction

    function automatic void purge(int d, int c);
        for (int q = 0; q < 4; q++) begin
            while (evq[q*2+d].size() > 0 && evq[q*2+d][$].cyc > c)
                void'(evq[q*2+d].pop_back());
        end
    endfunction

    // Monitor compares what each DUT presents this cycle, then the model absorbs this cycle's inputs.
    always @(negedge clk) begin
        obs_t o;
        ev_t  e;
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                o = obs[d];
                chk("busy", d, o.busy, (cyc >= lo[d] && cyc <= hi[d]) ? 1 : 0);
                if (take(d, o.load_en, "load_en", d, e)) last_load[d] = cyc;
                if (take(2 + d, o.bf_valid, "bf_valid", d, e)) begin
                    chk("stage", d, o.stage, e.s);
                    chk("addr_a", d, o.addr_a, e.a);
                    chk("addr_b", d, o.addr_b, e.b);
                    chk("tw_idx", d, o.tw, e.tw);
                    if (e.s == 2 && e.k == 5) begin
                        chk("s2k5_a", d, o.addr_a, 9);
                        chk("s2k5_b", d, o.addr_b, 13);
                        chk("s2k5_tw", d, o.tw, 8);
                    end
                    if (e.s == 5 && e.k == 31) begin
                        chk("s5k31_a", d, o.addr_a, 31);
                        chk("s5k31_b", d, o.addr_b, 63);
                        chk("s5k31_tw", d, o.tw, 31);
                    end
                    if (e.k == 0) begin
                        seen_mask[d] = '0;
                        seen_cnt[d] = 0;
                        if (e.s > 0) chk("wb_before_next_stage", d, (last_wb[d] < cyc) ? 1 : 0, 1);
                    end
                    chk("addr_unique", d, (seen_mask[d][o.addr_a] | seen_mask[d][o.addr_b]) ? 1 : 0, 0);
                    seen_mask[d][o.addr_a] = 1'b1;
                    seen_mask[d][o.addr_b] = 1'b1;
                    seen_cnt[d]++;
                    if (seen_cnt[d] == 32) chk("stage_cover", d, (seen_mask[d] == '1) ? 1 : 0, 1);
                end
                if (take(4 + d, o.wb_en, "wb_en", d, e)) begin
                    chk("wb_addr_a", d, o.wb_a, e.a);
                    chk("wb_addr_b", d, o.wb_b, e.b);
                    last_wb[d] = cyc;
                end
                if (take(6 + d, o.done, "done", d, e)) last_done[d] = cyc;
            end
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    purge(d, cyc);
                    if (hi[d] > cyc) hi[d] = cyc;
                end else if (cyc < lo[d] || cyc > hi[d]) begin
                    if (start_s[d]) push_job(d, cyc);
                end else if (abort_s[d]) begin
                    purge(d, cyc);
                    hi[d] = cyc;
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int d, output int c0);
        start_s[d] = 1'b1;
        c0 = cyc;
        tick();
        start_s[d] = 1'b0;
    endtask

    initial begin
        int c0;
        int ca;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        abort_s[0] = 1'b0;
        abort_s[1] = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("reset_outputs", 0, obs[0], 0);
        chk("reset_outputs", 1, obs[1], 0);
        mon_on = 1;
        tick(2);

        // single job, latency 2
        pulse_start(0, c0);
        tick(212);
        chk("done_cycle", 0, last_done[0] - c0, 206);
        chk("load_cycle", 0, last_load[0] - c0, 1);

        // start held high across two jobs
        start_s[0] = 1'b1;
        c0 = cyc;
        tick(300);
        start_s[0] = 1'b0;
        tick(200);
        chk("held_load2", 0, last_load[0] - c0, 208);
        chk("held_done2", 0, last_done[0] - c0, 413);

        // abort at stage 3, k 10, then a fresh job
        pulse_start(0, c0);
        ca = c0 + 2 + 3 * 34 + 10;
        tick(ca - cyc);
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        chk("abort_busy", 0, obs[0].busy, 0);
        chk("abort_bf_valid", 0, obs[0].bf_valid, 0);
        chk("abort_wb_en", 0, obs[0].wb_en, 0);
        tick(8);
        chk("abort_no_done", 0, (last_done[0] >= c0) ? 1 : 0, 0);
        pulse_start(0, c0);
        tick(210);
        chk("after_abort_done", 0, last_done[0] - c0, 206);

        // reset in the middle of stage 1
        pulse_start(0, c0);
        tick(c0 + 50 - cyc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_midrun_outputs", 0, obs[0], 0);
        tick(10);
        pulse_start(0, c0);
        tick(210);
        chk("after_rst_done", 0, last_done[0] - c0, 206);

        // latency-4 build
        pulse_start(1, c0);
        tick(224);
        chk("done_cycle_lat4", 1, last_done[1] - c0, 218);

        // randomized jobs: stray starts while busy, random aborts, abort with start in idle
        for (int it = 0; it < 8; it++) begin
            int d  = $urandom_range(0, 1);
            int jl = 2 + 6 * (32 + lat[d]);
            int st = $urandom_range(2, 30);
            int ab = $urandom_range(st + 1, jl);
            bit do_ab = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 6));
            abort_s[d] = 1'($urandom_range(0, 1));
            start_s[d] = 1'b1;
            for (int t = 1; t <= jl + 2; t++) begin
                tick();
                start_s[d] = (t == st);
                abort_s[d] = do_ab && (t == ab);
            end
            tick();
            start_s[d] = 1'b0;
            abort_s[d] = 1'b0;
        end

        tick(300);
        for (int q = 0; q < 8; q++) chk("pending_expected", q % 2, evq[q].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
